// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
package fetch_pkg;

  localparam int IQ_DEPTH   = 8;
  localparam int IQ_FETCH_W = 2;
  localparam int IQ_ISSUE_W = 2;

  localparam logic [31:0] INSTR_NOP = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ds;
  } iq_entry_t;

endpackage

// File: rtl/fetch_iq_ring.sv
// Circular entry storage: FETCH_W write ports at wr_ptr+i, ISSUE_W combinational read ports at rd_ptr+i.
// Storage is not reset; validity is tracked by the owner of the pointers.
module fetch_iq_ring
  import fetch_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH,
  parameter int FETCH_W = IQ_FETCH_W,
  parameter int ISSUE_W = IQ_ISSUE_W
) (
  input  logic                         clk,
  input  logic [FETCH_W-1:0]           i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_ptr,
  input  iq_entry_t [FETCH_W-1:0]      i_wr_dat,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_ptr,
  output iq_entry_t [ISSUE_W-1:0]      o_rd_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  iq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] w_wr_idx [FETCH_W];
  logic [PTR_W-1:0] w_rd_idx [ISSUE_W];

  // Pointer width equals log2(DEPTH), so the adds wrap modulo DEPTH for free.
  for (genvar g = 0; g < FETCH_W; g++) begin : g_wr_idx
    assign w_wr_idx[g] = i_wr_ptr + PTR_W'(g);
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
    assign w_rd_idx[g] = i_rd_ptr + PTR_W'(g);
    assign o_rd_dat[g] = r_mem[w_rd_idx[g]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (i_wr_en[i]) r_mem[w_wr_idx[i]] <= i_wr_dat[i];
    end
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// Fetch/decode instruction queue: push visible next cycle, show-ahead head slots, flush empties it.
// in_ready is conservative (pre-pop count); fetch holds its data while in_ready is low.
module fetch_instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH,
  parameter int FETCH_W = IQ_FETCH_W,
  parameter int ISSUE_W = IQ_ISSUE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic [FETCH_W-1:0]           i_in_valid,
  input  logic [32*FETCH_W-1:0]        i_in_pc,
  input  logic [32*FETCH_W-1:0]        i_in_instr,
  input  logic [FETCH_W-1:0]           i_in_ds,
  output logic                         o_in_ready,
  output logic [ISSUE_W-1:0]           o_out_valid,
  output logic [32*ISSUE_W-1:0]        o_out_pc,
  output logic [32*ISSUE_W-1:0]        o_out_pc_plus4,
  output logic [32*ISSUE_W-1:0]        o_out_instr,
  output logic [ISSUE_W-1:0]           o_out_ds,
  input  logic [ISSUE_W-1:0]           i_out_accept,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [CNT_W-1:0]          r_count;
  logic [FETCH_W-1:0]        w_wr_en;
  logic [CNT_W-1:0]          w_push_k;
  logic [CNT_W-1:0]          w_pop_j;
  iq_entry_t [FETCH_W-1:0]   w_wr_dat;
  iq_entry_t [ISSUE_W-1:0]   w_rd_dat;

  assign o_in_ready = (DEPTH - int'(r_count)) >= FETCH_W;
  assign w_wr_en    = (o_in_ready && !i_flush) ? i_in_valid : '0;
  assign o_count    = r_count;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_wr
    assign w_wr_dat[g] = '{pc: i_in_pc[32*g +: 32], instr: i_in_instr[32*g +: 32], ds: i_in_ds[g]};
  end

  // Empty slots present a nop bubble so decode never sees stale storage.
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
    assign o_out_valid[g]            = r_count > CNT_W'(g);
    assign o_out_pc[32*g +: 32]       = o_out_valid[g] ? w_rd_dat[g].pc : 32'h0;
    assign o_out_pc_plus4[32*g +: 32] = o_out_valid[g] ? w_rd_dat[g].pc + 32'd4 : 32'h0;
    assign o_out_instr[32*g +: 32]    = o_out_valid[g] ? w_rd_dat[g].instr : INSTR_NOP;
    assign o_out_ds[g]                = o_out_valid[g] & w_rd_dat[g].ds;
  end

  always_comb begin
    w_push_k = '0;
    w_pop_j  = '0;
    for (int i = 0; i < FETCH_W; i++) w_push_k += CNT_W'(w_wr_en[i]);
    for (int i = 0; i < ISSUE_W; i++) w_pop_j += CNT_W'(i_out_accept[i] & o_out_valid[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_j);
      r_tail  <= r_tail + PTR_W'(w_push_k);
      r_count <= r_count + w_push_k - w_pop_j;
    end
  end

  fetch_iq_ring #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W)
  ) u_ring (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_ptr (r_tail),
    .i_wr_dat (w_wr_dat),
    .i_rd_ptr (r_head),
    .o_rd_dat (w_rd_dat)
  );

  // Valid/accept vectors must be contiguous prefixes starting at slot 0.
  a_in_prefix: assert property (@(posedge clk) disable iff (rst)
    (i_in_valid & (i_in_valid + FETCH_W'(1))) == '0);
  a_acc_prefix: assert property (@(posedge clk) disable iff (rst)
    (i_out_accept & (i_out_accept + ISSUE_W'(1))) == '0);

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed scenarios plus random push/pop/flush against a queue model.
module tb_fetch_instr_queue;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [FW-1:0] in_valid = '0;
  logic [63:0]   in_pc = '0;
  logic [63:0]   in_instr = '0;
  logic [FW-1:0] in_ds = '0;
  logic          in_ready;
  logic [IW-1:0] out_valid;
  logic [63:0]   out_pc, out_pc_plus4, out_instr;
  logic [IW-1:0] out_ds;
  logic [IW-1:0] acc = '0;
  logic [3:0]    count;

  always #5 clk = ~clk;

  fetch_instr_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .i_in_pc        (in_pc),
    .i_in_instr     (in_instr),
    .i_in_ds        (in_ds),
    .o_in_ready     (in_ready),
    .o_out_valid    (out_valid),
    .o_out_pc       (out_pc),
    .o_out_pc_plus4 (out_pc_plus4),
    .o_out_instr    (out_instr),
    .o_out_ds       (out_ds),
    .i_out_accept   (acc),
    .o_count        (count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ds;
  } ent_t;

  ent_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [1:0] m_acc = '0;
  bit         m_flush = 1'b0;
  int         exp_vcnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Capture what decode offered at the edge so the monitor can retire it.
  always @(posedge clk) begin
    if (mon_en) begin
      m_acc   <= acc;
      m_flush <= flush;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int j;
      logic [127:0] e, a;
      j = 0;
      if (!m_flush)
        for (int i = 0; i < IW; i++) if (m_acc[i] && i < exp_vcnt) j++;
      repeat (j) void'(sb_q.pop_front());
      chk("count", 128'(count), 128'(sb_q.size()));
      chk("in_ready", 128'(in_ready), 128'((DEPTH - sb_q.size()) >= FW));
      for (int i = 0; i < IW; i++) begin
        e = '0;
        if (i < sb_q.size())
          e = {1'b1, sb_q[i].pc, sb_q[i].pc + 32'd4, sb_q[i].instr, sb_q[i].ds};
        a = {out_valid[i], out_pc[32*i +: 32], out_pc_plus4[32*i +: 32],
             out_instr[32*i +: 32], out_ds[i]};
        chk($sformatf("slot%0d", i), a, e);
      end
      exp_vcnt = (sb_q.size() < IW) ? sb_q.size() : IW;
    end
  end

  // Called at negedge+1; returns at the following negedge+1 with the edge applied.
  task automatic drive(input bit fl, input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] d,
                       input logic [1:0] a);
    flush    = fl;
    in_valid = v;
    in_pc    = {p1, p0};
    in_instr = {i1, i0};
    in_ds    = d;
    acc      = a;
    if (fl) sb_q.delete();
    else if ((DEPTH - sb_q.size()) >= FW) begin
      if (v[0]) sb_q.push_back('{p0, i0, d[0]});
      if (v[1]) sb_q.push_back('{p1, i1, d[1]});
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] a);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, a);
  endtask

  initial begin
    logic [1:0]  rv, ra;
    logic [31:0] rp0, rp1;
    bit          rf;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_instr", 128'(out_instr), 128'(0));
    idle(2'b00);
    idle(2'b11);

    drive(1'b0, 2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 32'h2402_0001, 32'h2403_0002, 2'b00, 2'b00);
    chk("first_valid", 128'(out_valid), 128'(2'b11));
    chk("first_pc4_s1", 128'(out_pc_plus4[63:32]), 128'(32'hBFC0_0008));
    chk("first_count", 128'(count), 128'(2));

    drive(1'b0, 2'b11, 32'hBFC0_0008, 32'hBFC0_000C, 32'h1111_0003, 32'h1111_0004, 2'b10, 2'b00);
    drive(1'b0, 2'b11, 32'hBFC0_0010, 32'hBFC0_0014, 32'h1111_0005, 32'h1111_0006, 2'b00, 2'b00);
    drive(1'b0, 2'b01, 32'hBFC0_0018, 32'h0, 32'h1111_0007, 32'h0, 2'b01, 2'b00);
    chk("full_count", 128'(count), 128'(7));
    chk("full_ready", 128'(in_ready), 128'(0));
    drive(1'b0, 2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 2'b00);
    chk("held_count", 128'(count), 128'(7));
    idle(2'b11);
    drive(1'b0, 2'b11, 32'hBFC0_001C, 32'hBFC0_0020, 32'h1111_0008, 32'h1111_0009, 2'b00, 2'b11);
    chk("wrap_count", 128'(count), 128'(5));
    idle(2'b11);
    idle(2'b11);
    chk("drain_count", 128'(count), 128'(1));

    drive(1'b0, 2'b01, 32'h8000_0100, 32'h0, 32'h0000_000C, 32'h0, 2'b01, 2'b01);
    chk("ds_count", 128'(count), 128'(1));
    chk("ds_flag", 128'(out_ds[0]), 128'(1));
    chk("ds_pc", 128'(out_pc[31:0]), 128'(32'h8000_0100));

    drive(1'b0, 2'b11, 32'h8000_0200, 32'h8000_0204, 32'h2222_0001, 32'h2222_0002, 2'b00, 2'b00);
    drive(1'b0, 2'b11, 32'h8000_0208, 32'h8000_020C, 32'h2222_0003, 32'h2222_0004, 2'b00, 2'b00);
    chk("preflush_count", 128'(count), 128'(5));
    drive(1'b1, 2'b11, 32'hBAD0_0000, 32'hBAD0_0004, 32'hBAD0_BAD0, 32'hBAD0_BAD1, 2'b11, 2'b11);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    idle(2'b00);

    drive(1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'h0340_0008, 32'h0, 2'b00, 2'b00);
    chk("pc4_wrap", 128'(out_pc_plus4[31:0]), 128'(32'h0));
    idle(2'b11);

    for (int c = 0; c < 10000; c++) begin
      rf  = ($urandom_range(0, 39) == 0);
      rv  = 2'(($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 3));
      ra  = 2'(($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 3));
      rp0 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      rp1 = $urandom;
      drive(rf, rv, rp0, rp1, $urandom, $urandom, 2'($urandom_range(0, 3)), ra);
    end
    idle(2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
